// File: rtl/logic_accumulator.sv
// logic_accumulator: bitwise logic unit with an accumulator operand and a small output FIFO.
// Revision 1.0
`default_nettype none

module logic_accumulator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]       DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]     PTR_ONE = AW'(1);
  localparam logic [AW:0]       CNT_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0]  OPS_ONE = CNT_W'(1);

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] ops;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head;

  assign in_ready   = !rst && (count < DEPTH_C);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head : '0;
  assign out_zero   = out_valid && (head == '0);
  assign out_parity = out_valid && (^head);
  assign acc_value  = acc;
  assign op_count   = ops;

  // A clear arriving with an accumulator-sourced op clears first, so A reads as zero.
  always_comb begin
    op_a = in_a;
    if (in_acc) begin
      op_a = acc_clr ? '0 : acc;
    end
  end

  always_comb begin
    result = op_a;
    case (in_op)
      OP_NAND: result = ~(op_a & in_b);
      OP_AND:  result = op_a & in_b;
      OP_OR:   result = op_a | in_b;
      OP_NOR:  result = ~(op_a | in_b);
      OP_XOR:  result = op_a ^ in_b;
      OP_XNOR: result = ~(op_a ^ in_b);
      OP_NOTA: result = ~op_a;
      default: result = op_a;
    endcase
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      ops    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (accept) begin
        acc <= result;
      end else if (acc_clr) begin
        acc <= '0;
      end
      if (accept && (ops != '1)) begin
        ops <= ops + OPS_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_accumulator.sv
// tb_logic_accumulator: directed vectors with a queue scoreboard and a decoupled output monitor.
`default_nettype none

module tb_logic_accumulator;

  localparam int W  = 8;
  localparam int CW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic          in_acc;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic          out_parity;
  logic [W-1:0]  acc_value;
  logic [CW-1:0] op_count;

  int            n_vec = 0;
  int            n_bad = 0;
  int            exp_cnt = 0;
  logic [W-1:0]  q[$];
  logic [W-1:0]  mon_e;

  logic_accumulator #(.WIDTH(W), .DEPTH(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_acc(in_acc),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_parity(out_parity),
    .acc_value(acc_value), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%0h, want no output", out_data);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_e));
        chk("out_zero", 64'(out_zero), 64'(mon_e == '0));
        chk("out_parity", 64'(out_parity), 64'(^mon_e));
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic clr, input logic [W-1:0] expv);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_acc   = sel;
    in_a     = a;
    in_b     = b;
    acc_clr  = clr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(expv);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    if (done) begin
      if (exp_cnt < CNT_MAX) exp_cnt++;
    end else begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, want accept of 0x%0h", expv);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    tick();
  endtask

  logic [W-1:0] tbl_b   [9] = '{8'hAC, 8'hAC, 8'hAC, 8'hAC, 8'hAC, 8'hAC, 8'hAC, 8'hAC, 8'h0F};
  logic [W-1:0] tbl_a   [9] = '{8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hF0};
  logic [2:0]   tbl_op  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
  logic [W-1:0] tbl_exp [9] = '{8'h77, 8'h88, 8'hEE, 8'h11, 8'h66, 8'h99, 8'h35, 8'hCA, 8'h00};
  logic [W-1:0] pass_v  [10] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'hFE};
  logic [W-1:0] acc_b   [3] = '{8'h01, 8'h02, 8'h80};
  logic [W-1:0] acc_e   [3] = '{8'h01, 8'h03, 8'h83};

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_acc = 1'b0;
    in_a = '0; in_b = '0; acc_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(acc_value), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single XOR op, latency 1
    out_ready = 1'b1;
    do_op(3'd4, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'hCC);
    chk("single_op_count", 64'(op_count), 64'(exp_cnt));
    drain();

    // Every opcode on a fixed operand pair, plus a zero result
    for (int i = 0; i < 9; i++) begin
      do_op(tbl_op[i], 1'b0, tbl_a[i], tbl_b[i], 1'b0, tbl_exp[i]);
      chk("op_table_acc", 64'(acc_value), 64'(tbl_exp[i]));
    end
    drain();

    // Accumulate chain after a standalone clear
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("clr_acc", 64'(acc_value), 64'd0);
    chk("clr_keeps_count", 64'(op_count), 64'(exp_cnt));
    for (int i = 0; i < 3; i++) begin
      do_op(3'd2, 1'b1, 8'h00, acc_b[i], 1'b0, acc_e[i]);
      chk("chain_acc", 64'(acc_value), 64'(acc_e[i]));
    end

    // Clear-then-operate with accumulator source
    do_op(3'd3, 1'b1, 8'h00, 8'h0F, 1'b1, 8'hF0);
    chk("clr_nor_acc", 64'(acc_value), 64'hF0);
    do_op(3'd4, 1'b0, 8'h12, 8'h34, 1'b1, 8'h26);
    chk("clr_ext_acc", 64'(acc_value), 64'h26);
    drain();

    // Backpressure: fill, hold third request, release one slot
    out_ready = 1'b0;
    do_op(3'd4, 1'b0, 8'h11, 8'h22, 1'b0, 8'h33);
    do_op(3'd1, 1'b0, 8'hFF, 8'h5A, 1'b0, 8'h5A);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_op = 3'd2; in_acc = 1'b0; in_a = 8'h40; in_b = 8'h04;
    tick(); tick();
    chk("full_hold_ready", 64'(in_ready), 64'd0);
    chk("full_hold_count", 64'(op_count), 64'(exp_cnt));
    chk("full_head", 64'(out_data), 64'h33);
    out_ready = 1'b1;
    @(negedge clk);
    chk("no_passthrough", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("slot_free_ready", 64'(in_ready), 64'd1);
    q.push_back(8'h44);
    tick();
    in_valid = 1'b0;
    if (exp_cnt < CNT_MAX) exp_cnt++;
    chk("third_accept_count", 64'(op_count), 64'(exp_cnt));
    out_ready = 1'b1;
    drain();

    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      do_op(3'd7, 1'b0, pass_v[i], 8'hFF, 1'b0, pass_v[i]);
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    drain();

    // Drive op_count into saturation
    for (int i = 0; i < 5; i++) do_op(3'd6, 1'b0, 8'h0F, 8'h00, 1'b0, 8'hF0);
    drain();
    chk("count_saturated", 64'(op_count), 64'(CNT_MAX));

    // Reset with two entries pending and acc = 0x55
    out_ready = 1'b0;
    do_op(3'd7, 1'b0, 8'h55, 8'h00, 1'b0, 8'h55);
    do_op(3'd7, 1'b0, 8'h55, 8'h00, 1'b0, 8'h55);
    chk("pre_rst_acc", 64'(acc_value), 64'h55);
    rst = 1'b1; in_valid = 1'b1; acc_clr = 1'b1; out_ready = 1'b1;
    tick();
    q.delete();
    exp_cnt = 0;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_flags", 64'({out_data, out_zero, out_parity}), 64'd0);
    chk("rst2_acc", 64'(acc_value), 64'd0);
    chk("rst2_op_count", 64'(op_count), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
    #1;
    chk("rst2_release_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    chk("empty_pop_ignored", 64'(out_valid), 64'd0);
    do_op(3'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00);
    chk("after_rst_count", 64'(op_count), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_accumulator.md
LOGIC_ACCUMULATOR -- requirements
Module: logic_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal 1..64.
REQ-002 SHALL have parameter DEPTH, default 2: output FIFO entries, power of two, legal 2..16.
REQ-003 SHALL have parameter CNT_W, default 16: transaction counter width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block can accept the request this cycle.
REQ-008 in_op  input  3  0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A.
REQ-009 in_acc  input  1  1: operand A is the accumulator; 0: operand A is in_a.
REQ-010 in_a  input  WIDTH  operand A when in_acc=0.
REQ-011 in_b  input  WIDTH  operand B; ignored for ops 6 and 7.
REQ-012 acc_clr  input  1  clear accumulator.
REQ-013 out_valid  output  1  FIFO head holds a result.
REQ-014 out_ready  input  1  consumer takes the head this cycle.
REQ-015 out_data  output  WIDTH  FIFO head result; 0 when empty.
REQ-016 out_zero  output  1  out_data == 0, qualified by out_valid (0 when empty).
REQ-017 out_parity  output  1  XOR-reduction of out_data, qualified by out_valid (0 when empty).
REQ-018 acc_value  output  WIDTH  current accumulator register.
REQ-019 op_count  output  CNT_W  accepted operations since reset, saturating.

Function
REQ-020 SHALL accept a request when in_valid && in_ready.
REQ-021 SHALL drive in_ready = 1 when FIFO count < DEPTH and rst = 0; no same-cycle pass-through when full.
REQ-022 SHALL compute result bitwise over all WIDTH bits per in_op, combinationally from the operands present in the accept cycle.
REQ-023 SHALL, on accept, load result into acc and push it into the FIFO, both visible the next cycle.
REQ-024 SHALL give latency 1: with an empty FIFO, out_valid = 1 and out_data = result on the cycle after accept.
REQ-025 SHALL pop the head when out_valid && out_ready; the next entry appears the following cycle.
REQ-026 SHALL leave count unchanged on simultaneous push and pop; order is strictly FIFO.
REQ-027 SHALL wrap FIFO pointers modulo DEPTH.
REQ-028 SHALL ignore out_ready while empty, with no count underflow.
REQ-029 SHALL use the acc value as updated by the previous accept for back-to-back in_acc=1 ops (no stale operand).
REQ-030 SHALL, on acc_clr without accept, set acc to 0 next cycle.
REQ-031 SHALL, on acc_clr with an in_acc=1 accept, use A = 0 and load acc with result (clear then operate).
REQ-032 SHALL, on acc_clr with an in_acc=0 accept, load acc with result.
REQ-033 SHALL never modify FIFO contents or op_count on acc_clr.
REQ-034 SHALL increment op_count by 1 per accept and hold at 2^CNT_W-1.

Reset
REQ-035 SHALL, while rst = 1, set acc = 0, FIFO empty, pointers = 0, op_count = 0, and in_ready = 0.
REQ-036 SHALL hold out_valid = 0, out_data = 0, out_zero = 0, out_parity = 0, and acc_value = 0 from the cycle after rst is sampled high.
REQ-037 SHALL give rst priority over a simultaneous accept, pop or acc_clr; in-flight FIFO entries are discarded.
REQ-038 SHALL raise in_ready on the first cycle after rst deasserts.

Verification
REQ-039 Single op: in_a=0xF0, in_b=0x3C, op=4 (XOR), accept -> next cycle out_valid=1, out_data=0xCC, out_parity=0, op_count=1.
REQ-040 Accumulate chain: acc_clr, then op=2 (OR) in_acc=1 with in_b=0x01, 0x02, 0x80 on consecutive cycles -> acc_value 0x01, 0x03, 0x83; FIFO outputs in that order.
REQ-041 Full/backpressure (DEPTH=2): out_ready=0, accept 2 ops -> in_ready=0; 3rd in_valid held; out_ready=1 for one cycle -> 3rd accepted the following cycle; no loss or reorder.
REQ-042 Simultaneous push/pop at count 1 -> count stays 1, data order preserved across pointer wrap over 10 ops.
REQ-043 acc_clr with accept, op=3 (NOR), in_acc=1, in_b=0x0F -> result 0xF0, acc_value=0xF0, FIFO head 0xF0.
REQ-044 rst asserted with 2 FIFO entries and acc=0x55 -> next cycle out_valid=0, acc_value=0, op_count=0; in_ready=1 the cycle after rst drops.
